// File: rtl/blood_sprite_reader.sv
// Pixel-side reader for the 64x64 blood-splatter sprite ROM: places the splatter around a hit
// point, addresses the ROM from the scan position and shows it for HOLD_FRAMES frames.
// Optional BLOOD_FADE_EN: halves every colour channel during the last quarter of the hold.
module blood_sprite_reader #(
    parameter int unsigned HOLD_FRAMES = 30,
    parameter int unsigned SPRITE_HALF = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        frame_tick,
    input  logic        hit,
    input  logic [9:0]  hit_x,
    input  logic [9:0]  hit_y,
    output logic [5:0]  rom_row,
    output logic [5:0]  rom_col,
    input  logic [11:0] rom_data,
    output logic        blood_on,
    output logic [11:0] rgb_out,
    output logic        busy
);

    localparam int unsigned CntW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(HOLD_FRAMES - 1);
    localparam logic [9:0] Half = 10'(SPRITE_HALF);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StShow
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] frame_cnt_q, frame_cnt_d;
    logic [9:0]      pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [9:0]      org_x_q, org_x_d, org_y_q, org_y_d;
    logic            retrig_q, retrig_d;
    logic            in_box_q;
    logic            blood_on_q;
    logic [11:0]     rgb_q;

    logic [9:0]  hit_org_x, hit_org_y;
    logic [10:0] dx, dy;
    logic        in_box;
    logic        fade;
    logic        pix_on;
    logic [11:0] pix_rgb;

    // Sprite origin may not go negative, so hits near the top/left clamp to 0.
    assign hit_org_x = (hit_x < Half) ? 10'd0 : hit_x - Half;
    assign hit_org_y = (hit_y < Half) ? 10'd0 : hit_y - Half;

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        org_x_d     = org_x_q;
        org_y_d     = org_y_q;
        retrig_d    = retrig_q;

        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    pend_x_d = hit_org_x;
                    pend_y_d = hit_org_y;
                    state_d  = StArmed;
                end
            end
            StArmed: begin
                if (frame_tick) begin
                    org_x_d     = pend_x_q;
                    org_y_d     = pend_y_q;
                    frame_cnt_d = CntLoad;
                    state_d     = StShow;
                    // A hit coinciding with activation is shown from the next frame on.
                    retrig_d    = hit;
                end
                if (hit) begin
                    pend_x_d = hit_org_x;
                    pend_y_d = hit_org_y;
                end
            end
            StShow: begin
                if (frame_tick) begin
                    if (retrig_q) begin
                        org_x_d     = pend_x_q;
                        org_y_d     = pend_y_q;
                        frame_cnt_d = CntLoad;
                        retrig_d    = 1'b0;
                    end else if (frame_cnt_q == '0) begin
                        state_d  = hit ? StArmed : StIdle;
                        retrig_d = 1'b0;
                    end else begin
                        frame_cnt_d = frame_cnt_q - CntW'(1);
                    end
                end
                if (hit) begin
                    pend_x_d = hit_org_x;
                    pend_y_d = hit_org_y;
                    if (state_d == StShow) begin
                        retrig_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            frame_cnt_q <= '0;
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            org_x_q     <= '0;
            org_y_q     <= '0;
            retrig_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            org_x_q     <= org_x_d;
            org_y_q     <= org_y_d;
            retrig_q    <= retrig_d;
        end
    end

    // Position relative to the sprite origin; bits above 5 set means outside 0..63.
    assign dx      = {1'b0, x} - {1'b0, org_x_q};
    assign dy      = {1'b0, y} - {1'b0, org_y_q};
    assign rom_row = dy[5:0];
    assign rom_col = dx[5:0];
    assign in_box  = video_on && (state_q == StShow) && (dx[10:6] == 5'd0) &&
                     (dy[10:6] == 5'd0);

`ifdef BLOOD_FADE_EN
    localparam logic [CntW-1:0] FadeThr = CntW'(HOLD_FRAMES / 4);
    assign fade = (state_q == StShow) && (frame_cnt_q < FadeThr);
`else
    assign fade = 1'b0;
`endif

    assign pix_on  = in_box_q && (rom_data != 12'h000);
    assign pix_rgb = fade ? {1'b0, rom_data[11:9], 1'b0, rom_data[7:5], 1'b0, rom_data[3:1]}
                          : rom_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_box_q   <= 1'b0;
            blood_on_q <= 1'b0;
            rgb_q      <= 12'h000;
        end else begin
            in_box_q   <= in_box;
            blood_on_q <= pix_on;
            rgb_q      <= pix_on ? pix_rgb : 12'h000;
        end
    end

    assign blood_on = blood_on_q;
    assign rgb_out  = rgb_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_blood_sprite_reader.sv
// Self-checking bench for blood_sprite_reader: directed table, corner sequences and random
// scan/hit traffic checked against a frame-level model of the splatter lifetime.
module tb_blood_sprite_reader;

    localparam int HOLD = 8;
    localparam int HALF = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        video_on = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        frame_tick = 1'b0;
    logic        hit = 1'b0;
    logic [9:0]  hit_x = '0;
    logic [9:0]  hit_y = '0;
    logic [5:0]  rom_row, rom_col;
    logic [11:0] rom_data = '0;
    logic        blood_on;
    logic [11:0] rgb_out;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    blood_sprite_reader #(
        .HOLD_FRAMES(HOLD),
        .SPRITE_HALF(HALF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .video_on  (video_on),
        .x         (x),
        .y         (y),
        .frame_tick(frame_tick),
        .hit       (hit),
        .hit_x     (hit_x),
        .hit_y     (hit_y),
        .rom_row   (rom_row),
        .rom_col   (rom_col),
        .rom_data  (rom_data),
        .blood_on  (blood_on),
        .rgb_out   (rgb_out),
        .busy      (busy)
    );

    function automatic logic [11:0] rom_fn(input int r, input int c);
        logic [11:0] v;
        if (r == 32 && c == 32) return 12'hE00;
        if (r == 31 && c == 63) return 12'h5A3;
        if (r == 1 && c == 1) return 12'h111;
        if (r == 0 && c == 0) return 12'h000;
        v = 12'((r * 37 + c * 11 + 5) ^ (r << 7));
        if (v[1:0] == 2'b00) v = 12'h000;
        return v;
    endfunction

    // Synchronous sprite ROM, one cycle of address-to-data latency.
    always @(posedge clk) rom_data <= rom_fn(int'(rom_row), int'(rom_col));

    // Model: frames of visibility left, plus an optional pending origin that the next
    // frame_tick promotes to the active origin.
    int m_rem, m_ax, m_ay, m_px, m_py;
    bit m_pv;
    bit e1_on, e2_on;
    logic [11:0] e1_rgb, e2_rgb;

    function automatic int clampo(input int h);
        return (h < HALF) ? 0 : h - HALF;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 'h%0h, expected 'h%0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rem = 0; m_pv = 0; m_ax = 0; m_ay = 0; m_px = 0; m_py = 0;
        e1_on = 0; e2_on = 0; e1_rgb = '0; e2_rgb = '0;
    endtask

    task automatic step(input bit h, input int hx, input int hy, input bit t, input bit v,
                        input int px, input int py);
        int dx, dy;
        bit on, fade;
        logic [11:0] c, rgb;
        hit = h; hit_x = 10'(hx); hit_y = 10'(hy); frame_tick = t;
        video_on = v; x = 10'(px); y = 10'(py);
        #1;
        dx = px - m_ax;
        dy = py - m_ay;
        check("rom_row", int'(rom_row), dy & 63);
        check("rom_col", int'(rom_col), dx & 63);
        c = rom_fn(dy & 63, dx & 63);
        on = v && (m_rem > 0) && dx >= 0 && dx < 64 && dy >= 0 && dy < 64 && c != 12'h000;
`ifdef BLOOD_FADE_EN
        fade = (m_rem > 0) && (m_rem - 1 < HOLD / 4);
`else
        fade = 0;
`endif
        rgb = !on ? 12'h000 : fade ? {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]} : c;
        @(posedge clk);
        #1;
        if (t) begin
            if (m_pv) begin
                m_ax = m_px; m_ay = m_py; m_rem = HOLD; m_pv = 0;
            end else if (m_rem > 0) begin
                m_rem--;
            end
        end
        if (h) begin
            m_px = clampo(hx); m_py = clampo(hy); m_pv = 1;
        end
        e2_on = e1_on; e2_rgb = e1_rgb;
        e1_on = on; e1_rgb = rgb;
        check("blood_on", int'(blood_on), int'(e2_on));
        check("rgb_out", int'(rgb_out), int'(e2_rgb));
        check("busy", int'(busy), int'(m_rem > 0 || m_pv));
        hit = 0; frame_tick = 0;
    endtask

    task automatic do_reset();
        hit = 0; frame_tick = 0; video_on = 0;
        reset = 1;
        #1;
        check("reset_blood_on", int'(blood_on), 0);
        check("reset_rgb", int'(rgb_out), 0);
        check("reset_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        step(0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic strike(input int hx, input int hy);
        step(1, hx, hy, 0, 0, 0, 0);
    endtask

    task automatic probe(input string nm, input bit v, input int px, input int py,
                         input int er, input int ec, input bit eon, input logic [11:0] ergb);
        hit = 0; frame_tick = 0; video_on = v; x = 10'(px); y = 10'(py);
        #1;
        check({nm, "_row"}, int'(rom_row), er);
        check({nm, "_col"}, int'(rom_col), ec);
        step(0, 0, 0, 0, v, px, py);
        idle();
        check({nm, "_on"}, int'(blood_on), int'(eon));
        check({nm, "_rgb"}, int'(rgb_out), int'(ergb));
    endtask

    typedef struct {
        int hx, hy;
        bit v;
        int px, py;
        int er, ec;
        bit eon;
        logic [11:0] ergb;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [11:0] fexp;
        tbl[0]  = '{200, 150, 1'b1, 168, 118,  0,  0, 1'b0, 12'h000};
        tbl[1]  = '{200, 150, 1'b1, 200, 150, 32, 32, 1'b1, 12'hE00};
        tbl[2]  = '{200, 150, 1'b0, 200, 150, 32, 32, 1'b0, 12'h000};
        tbl[3]  = '{200, 150, 1'b1, 167, 150, 32, 63, 1'b0, 12'h000};
        tbl[4]  = '{ 10,   5, 1'b1,   0,   0,  0,  0, 1'b0, 12'h000};
        tbl[5]  = '{ 10,   5, 1'b1,  64,  10, 10,  0, 1'b0, 12'h000};
        tbl[6]  = '{400, 300, 1'b1, 431, 299, 31, 63, 1'b1, 12'h5A3};
        tbl[7]  = '{400, 300, 1'b1, 400, 300, 32, 32, 1'b1, 12'hE00};
        tbl[8]  = '{ 31,  32, 1'b1,  32,  32, 32, 32, 1'b1, 12'hE00};
        tbl[9]  = '{  0,   0, 1'b1, 367,   0,  0, 47, 1'b0, 12'h000};
        tbl[10] = '{ 33,  33, 1'b1,   2,   2,  1,  1, 1'b1, 12'h111};

        model_reset();
        do_reset();
        // Idle scan: nothing shown, not busy.
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 100 + i, 50);
        tick();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, i, i);

        for (int i = 0; i < 11; i++) begin
            do_reset();
            strike(tbl[i].hx, tbl[i].hy);
            tick();
            probe($sformatf("tbl%0d", i), tbl[i].v, tbl[i].px, tbl[i].py, tbl[i].er,
                  tbl[i].ec, tbl[i].eon, tbl[i].ergb);
        end

        // Hold period, fade and expiry.
        do_reset();
        strike(200, 150);
        check("busy_after_hit", int'(busy), 1);
        tick();
        for (int f = 1; f <= HOLD; f++) begin
`ifdef BLOOD_FADE_EN
            fexp = (f >= 7) ? 12'h700 : 12'hE00;
`else
            fexp = 12'hE00;
`endif
            probe($sformatf("frame%0d", f), 1, 200, 150, 32, 32, 1, fexp);
            check("busy_hold", int'(busy), 1);
            tick();
        end
        check("busy_expired", int'(busy), 0);
        probe("expired", 1, 200, 150, 32, 32, 0, 12'h000);

        // Retrigger on the last frame wins over expiry.
        do_reset();
        strike(200, 150);
        tick();
        for (int i = 0; i < HOLD - 1; i++) tick();
        strike(400, 300);
        tick();
        probe("retrig_new", 1, 400, 300, 32, 32, 1, 12'hE00);
        probe("retrig_old", 1, 200, 150, 10, 24, 0, 12'h000);
        for (int i = 0; i < HOLD - 1; i++) tick();
        check("retrig_busy", int'(busy), 1);
        tick();
        check("retrig_expired", int'(busy), 0);

        // Hit together with frame_tick while showing: takes effect one frame later.
        do_reset();
        strike(200, 150);
        tick();
        step(1, 400, 300, 1, 0, 0, 0);
        probe("simul_new_early", 1, 400, 300, 54, 40, 0, 12'h000);
        probe("simul_old", 1, 200, 150, 32, 32, 1, 12'hE00);
        tick();
        probe("simul_new_late", 1, 400, 300, 32, 32, 1, 12'hE00);

        // Hit together with frame_tick from idle only arms.
        do_reset();
        step(1, 200, 150, 1, 0, 0, 0);
        check("idle_simul_busy", int'(busy), 1);
        probe("idle_simul_armed", 1, 200, 150, 22, 8, 0, 12'h000);
        tick();
        probe("idle_simul_show", 1, 200, 150, 32, 32, 1, 12'hE00);

        // Reset with pixels in flight.
        do_reset();
        strike(200, 150);
        tick();
        step(0, 0, 0, 0, 1, 200, 150);
        step(0, 0, 0, 0, 1, 200, 150);
        check("inflight_rgb", int'(rgb_out), 12'hE00);
        do_reset();
        idle();
        idle();
        check("post_reset_on", int'(blood_on), 0);

        // Random scan and hit traffic against the model.
        for (int fr = 0; fr < 60; fr++) begin
            if ($urandom_range(0, 19) == 0) do_reset();
            for (int p = 0; p < 30; p++) begin
                bit h;
                int hx, hy, px, py;
                h  = ($urandom_range(0, 29) == 0);
                hx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 639);
                hy = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 479);
                px = m_ax + $urandom_range(0, 80) - 8;
                py = m_ay + $urandom_range(0, 80) - 8;
                if (px < 0) px = 0;
                if (py < 0) py = 0;
                if (px > 1023) px = 1023;
                if (py > 1023) py = 1023;
                step(h, hx, hy, 0, $urandom_range(0, 3) != 0, px, py);
                if (p == 15 && $urandom_range(0, 29) == 0) do_reset();
            end
            idle();
            idle();
            step($urandom_range(0, 3) == 0, $urandom_range(0, 639), $urandom_range(0, 479), 1,
                 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/blood_sprite_reader.md
# blood_sprite_reader

Pixel-side reader for the 64×64 blood-splatter sprite ROM (6-bit row/col address, 12-bit RGB444 data, one-cycle registered address). It sits between the VGA timing generator and the final colour mux. On each hit event it positions the splatter around the impact point and drives ROM addresses from the scan position. It then emits a colour and a layer-enable for a fixed number of frames, treating colour 12'h000 as transparent.

## Interface
Parameters:
- `HOLD_FRAMES`, default 30: number of frames a splatter stays visible after activation.
- `SPRITE_HALF`, default 32: offset from the hit point to the sprite origin. The sprite is fixed at 64×64.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: reset, asynchronous, active-high.
- `video_on` in 1: scan position is inside the visible area.
- `x` in 10: current scan column.
- `y` in 10: current scan row.
- `frame_tick` in 1: one-cycle pulse at the start of vertical blank.
- `hit` in 1: one-cycle pulse; a hit has occurred.
- `hit_x` in 10: hit point column, sampled when `hit`=1.
- `hit_y` in 10: hit point row, sampled when `hit`=1.
- `rom_row` out 6: sprite ROM row address (combinational).
- `rom_col` out 6: sprite ROM column address (combinational).
- `rom_data` in 12: sprite ROM colour, valid one cycle after the address.
- `blood_on` out 1: this pixel shows a non-transparent splatter pixel.
- `rgb_out` out 12: splatter colour; 12'h000 when `blood_on`=0.
- `busy` out 1: a splatter is pending or being shown.

## Operation
State machine: IDLE, ARMED, SHOW.
- **IDLE**:
  - `hit` latches the pending origin and moves to ARMED.
  - Pending origin per axis: org = hit − `SPRITE_HALF`, clamped to 0 if hit < `SPRITE_HALF`.
- **ARMED**:
  - A further `hit` overwrites the pending origin.
  - `frame_tick` copies pending → active origin, loads frame_cnt = `HOLD_FRAMES`−1, and moves to SHOW.
- **SHOW**:
  - Each `frame_tick` with frame_cnt = 0 returns to IDLE; otherwise it decrements frame_cnt.
  - A `hit` latches a new pending origin and sets a retrigger flag.
  - At the next `frame_tick`, retrigger takes priority over expiry: pending → active, frame_cnt reloaded, flag cleared, stay in SHOW.
- **Simultaneous `hit` and `frame_tick`**: the `frame_tick` action uses the old pending origin; the new hit is latched for the following frame. From IDLE, simultaneous `hit`+`frame_tick` goes to ARMED only.
- **Origin changes**: the active origin changes only on `frame_tick`, so there is no mid-frame tearing.
- **Pixel path**:
  - dx = x − org_x and dy = y − org_y, computed 11-bit two's complement.
  - in_box = `video_on` & state==SHOW & 0≤dx≤63 & 0≤dy≤63.
  - `rom_row` = dy[5:0] and `rom_col` = dx[5:0] at all times; don't-care outside the box.
  - in_box is delayed one register to align with `rom_data`.
- **Output register**:
  - `blood_on` ← in_box_d & (`rom_data` ≠ 12'h000).
  - `rgb_out` ← `blood_on` ? colour : 12'h000.
- **Clipping**: the right and bottom edges clip naturally, since out-of-screen pixels never have `video_on`.
- `busy` = (state ≠ IDLE).

## Timing
- **Reset values**: state IDLE, frame_cnt 0, active and pending origins 0, retrigger 0, in_box_d 0; `blood_on`=0, `rgb_out`=12'h000, `busy`=0.
- **Reset mid-SHOW**: outputs are 0 from reset assertion onward, with no residual pixels after release.
- **Pixel latency**: x/y presented in cycle N → `blood_on`/`rgb_out` valid in cycle N+2.
- `rom_row`/`rom_col` are valid in cycle N.
- **Control timing**:
  - `busy` rises the cycle after `hit`.
  - SHOW starts the cycle after the `frame_tick`.
  - Visible for exactly `HOLD_FRAMES` full frames, then IDLE on the following `frame_tick`.

## Configuration
- `BLOOD_FADE_EN` defined:
  - While in SHOW with frame_cnt < `HOLD_FRAMES`/4 (integer division), each 4-bit channel of `rgb_out` is shifted right by 1.
  - A pixel whose halved colour is 12'h000 still asserts `blood_on`.
- `BLOOD_FADE_EN` undefined: full colour for the whole hold period.

## Test plan
- **Reset then idle**: `reset` pulse, one frame of scan with no hit → `blood_on`=0 and `rgb_out`=12'h000 every cycle; `busy`=0.
- **Basic render**: `hit` at (200,150) mid-frame, then `frame_tick` → in SHOW, x=168,y=118 drives row 0, col 0, and x=200,y=150 drives row 32, col 32. With ROM returning 12'hE00 for (32,32), `rgb_out`=12'hE00 two cycles after x=200 on row 150; the 12'h000 entry gives `blood_on`=0.
- **Edge clamp**: `hit` at (10,5) → origin (0,0); x=0,y=0 addresses row 0, col 0.
- **Expiry**: `HOLD_FRAMES`=3 → splatter visible in 3 consecutive frames; IDLE and `busy`=0 after the 4th `frame_tick`.
- **Retrigger and simultaneity**:
  - `hit` at (400,300) during SHOW with frame_cnt=0, then `frame_tick` → stays SHOW with origin (368,268) and frame_cnt reloaded.
  - `hit` coinciding with `frame_tick` → new origin takes effect one frame later.
- **Fade**, with `BLOOD_FADE_EN`, `HOLD_FRAMES`=8: ROM data 12'hE00 renders 12'hE00 for frames 1-6 and 12'h700 for frames 7-8. Without the macro: 12'hE00 for all 8 frames.
